mfcc_frame_sequencer: RTL

Frame-level controller for the MFCC front end. It sequences one frame at a time through three stages: window buffer, then Hamming window, then FFT/power. It holds each frame until the downstream mel stage accepts it, then advances the window buffer by one hop. The block replaces hard-wired `start_move`/`start` glue with a counted, abortable run of N frames and an optional per-stage watchdog.

---
 rtl/mfcc_frame_sequencer_pkg.sv | 29 ++
 rtl/mfcc_frame_sequencer_if.sv | 28 ++
 rtl/mfcc_frame_sequencer_watchdog.sv | 39 +++
 rtl/mfcc_frame_sequencer.sv | 153 +++++++++++++++
 4 files changed

// File: rtl/mfcc_frame_sequencer_pkg.sv
// mfcc_pkg: shared types and default constants for the MFCC front end.
//   seq_state_e      : frame sequencer FSM states
//   MFCC_FRAME_SIZE  : samples per analysis frame
//   MFCC_FRAME_MOVE  : hop between consecutive frames
//   MFCC_NFFT        : FFT length
//   seq_watched()    : states covered by the per-stage watchdog
package mfcc_pkg;

  localparam int unsigned MFCC_FRAME_SIZE = 400;
  localparam int unsigned MFCC_FRAME_MOVE = 160;
  localparam int unsigned MFCC_NFFT       = 512;

  typedef enum logic [2:0] {
    SEQ_IDLE,
    SEQ_WAIT_WIN,
    SEQ_HAMMING,
    SEQ_FFT,
    SEQ_WAIT_SINK,
    SEQ_MOVE,
    SEQ_DONE
  } seq_state_e;

  // WAIT_SINK is left out on purpose: sink backpressure may last indefinitely.
  function automatic logic seq_watched(input seq_state_e s);
    return (s == SEQ_WAIT_WIN) || (s == SEQ_HAMMING) ||
           (s == SEQ_FFT)      || (s == SEQ_MOVE);
  endfunction

endpackage

// File: rtl/mfcc_frame_sequencer_if.sv
// mfcc_frame_sequencer_if: stage handshake between the frame sequencer and
// the window buffer / Hamming / FFT / mel-sink stages.
//   master (sequencer): drives start_move_o, hamming_start_o, fft_start_o,
//                       frame_commit_o; samples the stage status inputs.
//   slave  (stages)   : the reverse direction.
interface mfcc_frame_sequencer_if;

  logic win_idle_i;
  logic win_ready_i;
  logic hamming_done_i;
  logic fft_done_i;
  logic sink_ready_i;
  logic start_move_o;
  logic hamming_start_o;
  logic fft_start_o;
  logic frame_commit_o;

  modport master (
    input  win_idle_i, win_ready_i, hamming_done_i, fft_done_i, sink_ready_i,
    output start_move_o, hamming_start_o, fft_start_o, frame_commit_o
  );

  modport slave (
    output win_idle_i, win_ready_i, hamming_done_i, fft_done_i, sink_ready_i,
    input  start_move_o, hamming_start_o, fft_start_o, frame_commit_o
  );

endinterface

// File: rtl/mfcc_frame_sequencer_watchdog.sv
// mfcc_seq_watchdog: per-stage cycle counter.
//   clk, rst_n : clock, synchronous active-low reset
//   clr_i      : first cycle of a new stage; counting restarts at this cycle
//   en_i       : current stage is watched
//   expire_o   : this is cycle TIMEOUT_CYCLES of the stage
module mfcc_seq_watchdog #(
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr_i,
  input  logic en_i,
  output logic expire_o
);

  localparam int unsigned W = (TIMEOUT_CYCLES < 2) ? 1 : $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [W-1:0] LAST = W'(TIMEOUT_CYCLES - 1);

  logic [W-1:0] count_q;
  logic [W-1:0] elapsed;

  // clr_i is seen in the stage's first cycle, so that cycle counts as 0
  // without waiting for the register to be cleared.
  assign elapsed  = clr_i ? '0 : count_q;
  assign expire_o = en_i && (elapsed == LAST);

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count_q <= '0;
    end else if (!en_i) begin
      count_q <= '0;
    end else if (elapsed != LAST) begin
      count_q <= elapsed + W'(1);
    end else begin
      count_q <= elapsed;
    end
  end

endmodule

// File: rtl/mfcc_frame_sequencer.sv
// mfcc_frame_sequencer: sequences a counted, abortable run of frames through
// window buffer -> Hamming -> FFT/power -> mel sink, sliding the window
// buffer by one hop between frames.
//   clk, rst_n    : clock, synchronous active-low reset
//   start_i       : pulse, begins a run of num_frames_i frames (0 ignored)
//   abort_i       : pulse, cancels the run
//   num_frames_i  : frames per run, sampled on an accepted start_i
//   stg           : stage handshake (mfcc_frame_sequencer_if.master)
//   frame_idx_o   : 0-based index of the frame in flight
//   busy_o        : high outside IDLE
//   done_o        : pulse, run finished normally
//   timeout_o     : sticky watchdog flag
// Optional feature: define MFCC_SEQ_WATCHDOG_EN to compile in the per-stage
// watchdog; otherwise timeout_o stays 0 and TIMEOUT_CYCLES is not used.
module mfcc_frame_sequencer
  import mfcc_pkg::*;
#(
  parameter int unsigned CNT_WIDTH      = 16,
  parameter int unsigned TIMEOUT_CYCLES = 65535
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      start_i,
  input  logic                      abort_i,
  input  logic [CNT_WIDTH-1:0]      num_frames_i,
  mfcc_frame_sequencer_if.master    stg,
  output logic [CNT_WIDTH-1:0]      frame_idx_o,
  output logic                      busy_o,
  output logic                      done_o,
  output logic                      timeout_o
);

  seq_state_e           state;
  logic [CNT_WIDTH-1:0] count_q;
  logic                 wd_expire;

  if (TIMEOUT_CYCLES == 0) begin : g_bad_timeout
    $error("TIMEOUT_CYCLES must be nonzero");
  end

`ifdef MFCC_SEQ_WATCHDOG_EN
  seq_state_e prev_state;
  logic       wd_clr;
  logic       wd_en;

  // A state change is detected one cycle late via prev_state; the watchdog
  // treats clr as "this is cycle 0" so the count is still exact.
  always_ff @(posedge clk) begin
    if (!rst_n) prev_state <= SEQ_IDLE;
    else        prev_state <= state;
  end

  assign wd_clr = (state != prev_state);
  assign wd_en  = seq_watched(state);

  mfcc_seq_watchdog #(
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) u_watchdog (
    .clk      (clk),
    .rst_n    (rst_n),
    .clr_i    (wd_clr),
    .en_i     (wd_en),
    .expire_o (wd_expire)
  );
`else
  assign wd_expire = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state               <= SEQ_IDLE;
      count_q             <= '0;
      frame_idx_o         <= '0;
      busy_o              <= 1'b0;
      done_o              <= 1'b0;
      timeout_o           <= 1'b0;
      stg.start_move_o    <= 1'b0;
      stg.hamming_start_o <= 1'b0;
      stg.fft_start_o     <= 1'b0;
      stg.frame_commit_o  <= 1'b0;
    end else begin
      stg.start_move_o    <= 1'b0;
      stg.hamming_start_o <= 1'b0;
      stg.fft_start_o     <= 1'b0;
      stg.frame_commit_o  <= 1'b0;
      done_o              <= 1'b0;

      // Abort outranks any stage event and the watchdog in the same cycle.
      if (abort_i && (state != SEQ_IDLE)) begin
        state  <= SEQ_IDLE;
        busy_o <= 1'b0;
      end else if (wd_expire) begin
        state     <= SEQ_IDLE;
        busy_o    <= 1'b0;
        timeout_o <= 1'b1;
      end else begin
        case (state)
          SEQ_IDLE: begin
            if (start_i && (num_frames_i != '0)) begin
              count_q     <= num_frames_i;
              frame_idx_o <= '0;
              timeout_o   <= 1'b0;
              busy_o      <= 1'b1;
              state       <= SEQ_WAIT_WIN;
            end
          end
          SEQ_WAIT_WIN: begin
            if (stg.win_ready_i) begin
              stg.hamming_start_o <= 1'b1;
              state               <= SEQ_HAMMING;
            end
          end
          SEQ_HAMMING: begin
            if (stg.hamming_done_i) begin
              stg.fft_start_o <= 1'b1;
              state           <= SEQ_FFT;
            end
          end
          SEQ_FFT: begin
            if (stg.fft_done_i) state <= SEQ_WAIT_SINK;
          end
          SEQ_WAIT_SINK: begin
            if (stg.sink_ready_i) begin
              stg.frame_commit_o <= 1'b1;
              if (frame_idx_o == count_q - CNT_WIDTH'(1)) begin
                done_o <= 1'b1;
                state  <= SEQ_DONE;
              end else begin
                frame_idx_o <= frame_idx_o + CNT_WIDTH'(1);
                state       <= SEQ_MOVE;
              end
            end
          end
          SEQ_MOVE: begin
            if (stg.win_idle_i) begin
              stg.start_move_o <= 1'b1;
              state            <= SEQ_WAIT_WIN;
            end
          end
          SEQ_DONE: begin
            busy_o <= 1'b0;
            state  <= SEQ_IDLE;
          end
          default: begin
            busy_o <= 1'b0;
            state  <= SEQ_IDLE;
          end
        endcase
      end
    end
  end

endmodule
